ascon_job_ctrl: RTL and testbench

Job sequencer for the ASCON DMA engines in the user domain. It accepts one job descriptor: key, command, input-data, output-data and tag addresses plus lengths. It then issues address commands to the three read DMAs (cmd, key, bdi) and the two write DMAs (auth/tag, bdo) in a fixed order, tracks their completion, and reports busy, done and error status to the register front end. Only one job is in flight at a time.

---
 rtl/ascon_job_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_ascon_job_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_job_ctrl.sv
// ascon_job_ctrl: single-job sequencer for the ASCON DMA engines.
// Latches one descriptor on start, issues key/cmd/bdi read commands and bdo/tag write
// commands in fixed order, tracks outstanding completions and reports busy/done/error.
// Optional watchdog: define ASCON_JOB_TIMEOUT_EN to abort a job after TIMEOUT_CYCLES
// cycles without a handshake or accepted completion.

module ascon_job_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned KEY_BYTES      = 16,
  parameter int unsigned TAG_BYTES      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        mode_i,
  input  logic [31:0] key_addr_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] bdi_addr_i,
  input  logic [31:0] bdo_addr_i,
  input  logic [31:0] tag_addr_i,
  input  logic [31:0] cmd_len_i,
  input  logic [31:0] data_len_i,
  output logic [2:0]  rd_valid_o,
  input  logic [2:0]  rd_ready_i,
  output logic [31:0] rd_addr_o,
  output logic [31:0] rd_len_o,
  input  logic [2:0]  rd_done_i,
  output logic [1:0]  wr_valid_o,
  input  logic [1:0]  wr_ready_i,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_len_o,
  input  logic [1:0]  wr_done_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [4:0]  pending_o
);

  typedef enum logic [2:0] {StIdle, StKey, StCmd, StBdi, StBdo, StTag, StWait} state_e;

  // Next issue state after a completed handshake, applying the descriptor skips.
  function automatic state_e next_issue(input state_e cur, input logic cmd_nz,
                                        input logic data_nz, input logic tag_en);
    state_e nxt;
    case (cur)
      StKey:   nxt = cmd_nz ? StCmd : (data_nz ? StBdi : (tag_en ? StTag : StWait));
      StCmd:   nxt = data_nz ? StBdi : (tag_en ? StTag : StWait);
      StBdi:   nxt = StBdo;
      StBdo:   nxt = tag_en ? StTag : StWait;
      default: nxt = StWait;
    endcase
    return nxt;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  rd_valid_q, rd_valid_d;
  logic [1:0]  wr_valid_q, wr_valid_d;
  logic [31:0] rd_addr_q, rd_addr_d, rd_len_q, rd_len_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_len_q, wr_len_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [4:0]  pending_q, pending_d;

  // Latched descriptor (key address is consumed directly in the start cycle)
  logic [31:0] cmd_addr_q, bdi_addr_q, bdo_addr_q, tag_addr_q, cmd_len_q, data_len_q;
  logic        mode_q;

  logic        start_acc;
  logic [4:0]  done_vec, hs_vec;
  logic        timeout;

  assign start_acc = (state_q == StIdle) && start_i;
  // Bit order {bdo, tag, bdi, key, cmd} matches {wr[1], wr[0], rd[2], rd[1], rd[0]}
  assign done_vec  = {wr_done_i, rd_done_i};
  assign hs_vec    = {wr_valid_q & wr_ready_i, rd_valid_q & rd_ready_i};

`ifdef ASCON_JOB_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntFire = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Progress watchdog: counts cycles since the last start/handshake/accepted done
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = start_i ? CntW'(1) : '0;
    end else if ((|hs_vec) || (|(done_vec & pending_q))) begin
      cnt_d = CntW'(1);
    end else begin
      timeout = (cnt_q == CntFire);
      cnt_d   = cnt_q + CntW'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Sequencer next state, pending tracking and registered command/status outputs
  always_comb begin
    state_d    = state_q;
    pending_d  = (pending_q & ~done_vec) | hs_vec;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    rd_valid_d = '0;
    wr_valid_d = '0;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StKey;
          pending_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          rd_addr_d = key_addr_i;
          rd_len_d  = 32'(KEY_BYTES);
        end
      end
      StWait: begin
        // Uses the post-clear view so completion shows one cycle after the last done
        if (pending_d == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (|hs_vec) begin
          state_d = next_issue(state_q, |cmd_len_q, |data_len_q, mode_q);
        end
      end
    endcase

    if ((state_q != StIdle) && (abort_i || timeout)) begin
      state_d   = StIdle;
      pending_d = '0;
      busy_d    = 1'b0;
      error_d   = 1'b1;
    end

    // Command outputs follow the state being entered; addr/len hold otherwise
    case (state_d)
      StKey: rd_valid_d = 3'b010;
      StCmd: begin
        rd_valid_d = 3'b001;
        rd_addr_d  = cmd_addr_q;
        rd_len_d   = cmd_len_q;
      end
      StBdi: begin
        rd_valid_d = 3'b100;
        rd_addr_d  = bdi_addr_q;
        rd_len_d   = data_len_q;
      end
      StBdo: begin
        wr_valid_d = 2'b10;
        wr_addr_d  = bdo_addr_q;
        wr_len_d   = data_len_q;
      end
      StTag: begin
        wr_valid_d = 2'b01;
        wr_addr_d  = tag_addr_q;
        wr_len_d   = 32'(TAG_BYTES);
      end
      default: ;
    endcase
  end

  // State, output and descriptor registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rd_valid_q <= '0;
      wr_valid_q <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      pending_q  <= '0;
      cmd_addr_q <= '0;
      bdi_addr_q <= '0;
      bdo_addr_q <= '0;
      tag_addr_q <= '0;
      cmd_len_q  <= '0;
      data_len_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      pending_q  <= pending_d;
      if (start_acc) begin
        cmd_addr_q <= cmd_addr_i;
        bdi_addr_q <= bdi_addr_i;
        bdo_addr_q <= bdo_addr_i;
        tag_addr_q <= tag_addr_i;
        cmd_len_q  <= cmd_len_i;
        data_len_q <= data_len_i;
        mode_q     <= mode_i;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign wr_valid_o = wr_valid_q;
  assign rd_addr_o  = rd_addr_q;
  assign rd_len_o   = rd_len_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_len_o   = wr_len_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign pending_o  = pending_q;

endmodule

// File: tb/tb_ascon_job_ctrl.sv
// Directed testbench for ascon_job_ctrl (TIMEOUT_CYCLES=32).
module tb_ascon_job_ctrl;

  localparam logic [31:0] KeyA = 32'h1000_0100;
  localparam logic [31:0] CmdA = 32'h2000_0200;
  localparam logic [31:0] BdiA = 32'h3000_0300;
  localparam logic [31:0] BdoA = 32'h4000_0400;
  localparam logic [31:0] TagA = 32'h5000_0500;
  localparam int unsigned DoneDly = 10;

  logic        clk = 1'b0;
  logic        rst, start, abort, mode;
  logic [31:0] key_addr, cmd_addr, bdi_addr, bdo_addr, tag_addr, cmd_len, data_len;
  logic [2:0]  rd_valid, rd_ready, rd_done, man_rd;
  logic [1:0]  wr_valid, wr_ready, wr_done, man_wr;
  logic [31:0] rd_addr, rd_len, wr_addr, wr_len;
  logic        busy, done, error;
  logic [4:0]  pending;

  logic        auto_en;
  logic [4:0]  auto_done = '0;
  logic [4:0]  hs_now;
  int unsigned cd [5];

  int vectors = 0;
  int miscompares = 0;

  assign rd_done = auto_done[2:0] | man_rd;
  assign wr_done = auto_done[4:3] | man_wr;
  assign hs_now  = {wr_valid & wr_ready, rd_valid & rd_ready};

  always #5 clk = ~clk;

  ascon_job_ctrl #(
    .TIMEOUT_CYCLES(32),
    .KEY_BYTES     (16),
    .TAG_BYTES     (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .abort_i   (abort),
    .mode_i    (mode),
    .key_addr_i(key_addr),
    .cmd_addr_i(cmd_addr),
    .bdi_addr_i(bdi_addr),
    .bdo_addr_i(bdo_addr),
    .tag_addr_i(tag_addr),
    .cmd_len_i (cmd_len),
    .data_len_i(data_len),
    .rd_valid_o(rd_valid),
    .rd_ready_i(rd_ready),
    .rd_addr_o (rd_addr),
    .rd_len_o  (rd_len),
    .rd_done_i (rd_done),
    .wr_valid_o(wr_valid),
    .wr_ready_i(wr_ready),
    .wr_addr_o (wr_addr),
    .wr_len_o  (wr_len),
    .wr_done_i (wr_done),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error),
    .pending_o (pending)
  );

  // DMA model: completes each accepted command DoneDly cycles after its handshake cycle
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (!auto_en || rst) begin
        cd[i]        <= 0;
        auto_done[i] <= 1'b0;
      end else begin
        auto_done[i] <= (cd[i] == 1);
        if (hs_now[i]) cd[i] <= DoneDly - 1;
        else if (cd[i] != 0) cd[i] <= cd[i] - 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_rdv"}, rd_valid, 0);
    chk({tag, "_wrv"}, wr_valid, 0);
    chk({tag, "_rdaddr"}, rd_addr, 0);
    chk({tag, "_rdlen"}, rd_len, 0);
    chk({tag, "_wraddr"}, wr_addr, 0);
    chk({tag, "_wrlen"}, wr_len, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; start = 0; abort = 0; mode = 1;
    key_addr = KeyA; cmd_addr = CmdA; bdi_addr = BdiA; bdo_addr = BdoA; tag_addr = TagA;
    cmd_len = 8; data_len = 64;
    rd_ready = 3'b111; wr_ready = 2'b11; man_rd = '0; man_wr = '0; auto_en = 0;
    step();
    start = 1;                       // start coincident with reset must be ignored
    step();
    rst = 0; start = 0;
    chk_reset_vals("rst");
    step();
    chk("rst_start_ign_busy", busy, 0);
    chk("rst_start_ign_rdv", rd_valid, 0);

    // Full job, all readies high, dones 10 cycles after each issue
    auto_en = 1; start = 1;
    step(); start = 0;                                      // N+1
    chk("full_busy", busy, 1);
    chk("full_key_v", rd_valid, 3'b010);
    chk("full_key_a", rd_addr, KeyA);
    chk("full_key_l", rd_len, 16);
    step();                                                 // N+2
    chk("full_cmd_v", rd_valid, 3'b001);
    chk("full_cmd_a", rd_addr, CmdA);
    chk("full_cmd_l", rd_len, 8);
    step();                                                 // N+3
    chk("full_bdi_v", rd_valid, 3'b100);
    chk("full_bdi_a", rd_addr, BdiA);
    chk("full_bdi_l", rd_len, 64);
    step();                                                 // N+4
    chk("full_bdo_rdv", rd_valid, 0);
    chk("full_bdo_v", wr_valid, 2'b10);
    chk("full_bdo_a", wr_addr, BdoA);
    chk("full_bdo_l", wr_len, 64);
    chk("full_rdaddr_hold", rd_addr, BdiA);
    step();                                                 // N+5
    chk("full_tag_v", wr_valid, 2'b01);
    chk("full_tag_a", wr_addr, TagA);
    chk("full_tag_l", wr_len, 16);
    step();                                                 // N+6
    chk("full_wait_wrv", wr_valid, 0);
    chk("full_pend_all", pending, 5'h1F);
    repeat (9) step();                                      // N+15
    chk("full_pend_last", pending, 5'h08);
    chk("full_not_done", done, 0);
    chk("full_still_busy", busy, 1);
    step();                                                 // N+16
    chk("full_done", done, 1);
    chk("full_idle_busy", busy, 0);
    chk("full_pend_zero", pending, 0);

    // Skips: data_len=0, mode=0
    data_len = 0; mode = 0; start = 1;
    step(); start = 0;                                      // N+1
    chk("skip_done_clr", done, 0);
    chk("skip_key_v", rd_valid, 3'b010);
    step();                                                 // N+2
    chk("skip_cmd_v", rd_valid, 3'b001);
    step();                                                 // N+3
    chk("skip_rdv", rd_valid, 0);
    chk("skip_wrv", wr_valid, 0);
    chk("skip_pend_peak", pending, 5'h03);
    chk("skip_busy", busy, 1);
    repeat (9) step();                                      // N+12
    chk("skip_pend_cmd", pending, 5'h01);
    step();                                                 // N+13
    chk("skip_done", done, 1);
    chk("skip_idle", busy, 0);

    // Backpressure on bdi, then abort in WAIT
    auto_en = 0; cmd_len = 0; data_len = 64; mode = 1; rd_ready = 3'b011;
    step();
    start = 1;
    step(); start = 0;                                      // N+1
    chk("bp_key_v", rd_valid, 3'b010);
    step();                                                 // N+2
    for (int i = 0; i < 7; i++) begin
      chk("bp_hold_v", rd_valid, 3'b100);
      chk("bp_hold_a", rd_addr, BdiA);
      chk("bp_hold_l", rd_len, 64);
      chk("bp_hold_wrv", wr_valid, 0);
      man_rd = (i == 1) ? 3'b010 : 3'b000;                  // key completes meanwhile
      step();
    end                                                     // N+9
    chk("bp_still_v", rd_valid, 3'b100);
    rd_ready = 3'b111;
    step();                                                 // N+10
    chk("bp_bdo_rdv", rd_valid, 0);
    chk("bp_bdo_v", wr_valid, 2'b10);
    chk("bp_bdo_a", wr_addr, BdoA);
    step();                                                 // N+11
    chk("bp_tag_v", wr_valid, 2'b01);
    step();                                                 // N+12
    chk("bp_pend_wait", pending, 5'h1C);
    man_wr = 2'b01; man_rd = 3'b001;                        // cmd done is not pending
    step(); man_wr = 0; man_rd = 0;                         // N+13
    chk("ab_pend_pre", pending, 5'h14);
    chk("ab_busy_pre", busy, 1);
    abort = 1;
    step(); abort = 0;                                      // N+14
    chk("ab_error", error, 1);
    chk("ab_busy", busy, 0);
    chk("ab_pend", pending, 0);
    chk("ab_rdv", rd_valid, 0);
    chk("ab_wrv", wr_valid, 0);
    chk("ab_done", done, 0);
    man_rd = 3'b100;                                        // late bdi done
    step(); man_rd = 0;                                     // N+15
    chk("late_error", error, 1);
    chk("late_busy", busy, 0);
    chk("late_pend", pending, 0);
    chk("late_done", done, 0);

    // Start while busy ignored, then reset mid-job
    cmd_len = 8; data_len = 64; mode = 1;
    start = 1;
    step(); start = 0;                                      // N+1
    chk("sb_err_clr", error, 0);
    chk("sb_key_v", rd_valid, 3'b010);
    step();                                                 // N+2
    step();                                                 // N+3
    key_addr = 32'hDEAD_0000; start = 1;
    step(); start = 0; key_addr = KeyA;                     // N+4
    chk("sb_ign_rdv", rd_valid, 0);
    chk("sb_ign_wrv", wr_valid, 2'b10);
    chk("sb_ign_wra", wr_addr, BdoA);
    step();                                                 // N+5
    step();                                                 // N+6
    chk("sb_busy", busy, 1);
    chk("sb_pend", pending, 5'h1F);
    rst = 1;
    step(); rst = 0;
    chk_reset_vals("midrst");
    step();
    chk("midrst_idle", busy, 0);

    // Watchdog: no done pulses returned
    cmd_len = 8; data_len = 0; mode = 0;
    start = 1;
    step(); start = 0;                                      // N+1
    step();                                                 // N+2, last handshake
    step();                                                 // N+3
    chk("to_pend", pending, 5'h03);
    repeat (30) step();                                     // N+33
    chk("to_pre_err", error, 0);
    chk("to_pre_busy", busy, 1);
    step();                                                 // N+34
`ifdef ASCON_JOB_TIMEOUT_EN
    chk("to_error", error, 1);
    chk("to_busy", busy, 0);
    chk("to_pend_clr", pending, 0);
`else
    chk("nto_error", error, 0);
    chk("nto_busy", busy, 1);
    chk("nto_pend", pending, 5'h03);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
